// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC serial frame transmitter.
package dac_pkg;

    localparam int unsigned DAC_FRAME_W    = 24;
    localparam logic [3:0]  DAC_CMD_WR_UPD = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } dac_tx_state_t;

endpackage

// File: rtl/dac_sclk_div.sv
// Half-period strobe generator: pulses hp_tick_c every CLK_DIV enabled cycles.
module dac_sclk_div
    import dac_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic hp_tick_c
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign hp_tick_c = en && (cnt_q == DIV_W'(CLK_DIV - 1));

    // Count enabled cycles; restart at the terminal count, on clear, or while disabled
    always_comb begin
        cnt_d = cnt_q;
        if (!en || clr || hp_tick_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Divider counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_frame_tx.sv
// Serialises one bit-reversed command word onto the 3-wire DAC interface
// (sync_n / sclk / din), LSB of cmd first, with a start/busy/done handshake.
// Optional: define DAC_FRAME_ABORT_EN to add an abort input that ends a
// frame early (sync_n raised, no done pulse, gap still observed).
module dac_frame_tx
    import dac_pkg::*;
#(
    parameter int unsigned FRAME_W = DAC_FRAME_W,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned GAP_HP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FRAME_W-1:0] cmd,
`ifdef DAC_FRAME_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic               done,
    output logic               sync_n,
    output logic               sclk,
    output logic               din
);

    localparam int unsigned BIT_W = $clog2(FRAME_W);
    localparam int unsigned GAP_W = (GAP_HP > 1) ? $clog2(GAP_HP) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_HP > 0) ? GAP_HP - 1 : 0);

    dac_tx_state_t      state_q, state_d;
    logic [FRAME_W-1:0] sr_q, sr_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               sync_n_q, sync_n_d;
    logic               sclk_q, sclk_d;
    logic               din_q, din_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_en_c;
    logic               div_clr_c;
    logic               hp_tick_c;
    logic               abort_c;

`ifdef DAC_FRAME_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    assign div_en_c = (state_q != IDLE);

    dac_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .en        (div_en_c),
        .clr       (div_clr_c),
        .hp_tick_c (hp_tick_c)
    );

    assign busy   = busy_q;
    assign done   = done_q;
    assign sync_n = sync_n_q;
    assign sclk   = sclk_q;
    assign din    = din_q;

    // Next-state and output decode for the IDLE -> SHIFT -> GAP sequence
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_d     = bit_q;
        gap_d     = gap_q;
        sync_n_d  = sync_n_q;
        sclk_d    = sclk_q;
        din_d     = din_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        div_clr_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SHIFT;
                    sr_d     = cmd;
                    bit_d    = '0;
                    sync_n_d = 1'b0;
                    sclk_d   = 1'b1;
                    din_d    = cmd[0];
                    busy_d   = 1'b1;
                end
            end

            SHIFT: begin
                if (abort_c) begin
                    // Early sync rise makes the DAC discard the partial frame
                    sync_n_d  = 1'b1;
                    sclk_d    = 1'b1;
                    din_d     = 1'b0;
                    gap_d     = '0;
                    div_clr_c = 1'b1;
                    if (GAP_HP == 0) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = GAP;
                    end
                end else if (hp_tick_c) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (bit_q == BIT_LAST) begin
                        sync_n_d = 1'b1;
                        sclk_d   = 1'b1;
                        din_d    = 1'b0;
                        done_d   = 1'b1;
                        gap_d    = '0;
                        if (GAP_HP == 0) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        sclk_d = 1'b1;
                        sr_d   = sr_q >> 1;
                        din_d  = sr_q[1];
                        bit_d  = bit_q + BIT_W'(1);
                    end
                end
            end

            GAP: begin
                if (hp_tick_c) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered-output flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            bit_q    <= '0;
            gap_q    <= '0;
            sync_n_q <= 1'b1;
            sclk_q   <= 1'b1;
            din_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            sync_n_q <= sync_n_d;
            sclk_q   <= sclk_d;
            din_q    <= din_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_dac_frame_tx.sv
// Bench for dac_frame_tx: two instances (CLK_DIV=2/GAP_HP=4 and CLK_DIV=1/GAP_HP=0).
// Abort steps are compiled in when DAC_FRAME_ABORT_EN is defined.
module tb_dac_frame_tx;

    localparam int W     = 24;
    localparam int CD_A  = 2;
    localparam int GAP_A = 4;
    localparam int CD_B  = 1;
    localparam int GAP_B = 0;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_a = 1'b0, start_b = 1'b0, abort_a = 1'b0;
    logic [W-1:0] cmd_a = '0, cmd_b = '0;
    logic         busy_a, done_a, sync_n_a, sclk_a, din_a;
    logic         busy_b, done_b, sync_n_b, sclk_b, din_b;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_frame_tx #(.FRAME_W(W), .CLK_DIV(CD_A), .GAP_HP(GAP_A)) u_a (
        .clk    (clk),
        .rst    (rst),
        .start  (start_a),
        .cmd    (cmd_a),
`ifdef DAC_FRAME_ABORT_EN
        .abort  (abort_a),
`endif
        .busy   (busy_a),
        .done   (done_a),
        .sync_n (sync_n_a),
        .sclk   (sclk_a),
        .din    (din_a)
    );

    dac_frame_tx #(.FRAME_W(W), .CLK_DIV(CD_B), .GAP_HP(GAP_B)) u_b (
        .clk    (clk),
        .rst    (rst),
        .start  (start_b),
        .cmd    (cmd_b),
`ifdef DAC_FRAME_ABORT_EN
        .abort  (1'b0),
`endif
        .busy   (busy_b),
        .done   (done_b),
        .sync_n (sync_n_b),
        .sclk   (sclk_b),
        .din    (din_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word as the DAC assembles it: first bit on the wire becomes the MSB
    function automatic logic [W-1:0] bitrev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[W-1-i] = v[i];
        return r;
    endfunction

    // Observe one frame from the cycle after start was raised until busy drops after done
    task automatic mon(input bit sel, input bit hold, input int budget, input int pulse_at,
                       output int t_fall, output int n_low, output int n_edges,
                       output logic [W-1:0] rx, output int t_done, output int n_done,
                       output int t_idle);
        logic prev, s, k, d, dn, b;
        prev = 1'b1; t_fall = -1; n_low = 0; n_edges = 0; rx = '0;
        t_done = -1; n_done = 0; t_idle = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (i == 0 && !hold) begin
                if (sel) start_b = 1'b0; else start_a = 1'b0;
            end
            if (pulse_at >= 0 && i == pulse_at) begin
                start_a = 1'b1;
                cmd_a = W'($urandom);
            end
            if (pulse_at >= 0 && i == pulse_at + 1) start_a = 1'b0;
            s  = sel ? sync_n_b : sync_n_a;
            k  = sel ? sclk_b   : sclk_a;
            d  = sel ? din_b    : din_a;
            dn = sel ? done_b   : done_a;
            b  = sel ? busy_b   : busy_a;
            if (!s) begin
                n_low++;
                if (t_fall < 0) t_fall = cyc;
                if (prev && !k) begin
                    rx = {rx[W-2:0], d};
                    n_edges++;
                end
            end
            if (dn) begin
                n_done++;
                if (t_done < 0) t_done = cyc;
            end
            if (t_done >= 0 && !b) begin
                t_idle = cyc;
                break;
            end
            prev = k;
        end
    endtask

    // Compare observed frame against the timing/data rules for a frame accepted at T
    task automatic chk_frame(input string tag, input int T, input int cd, input int gap,
                             input logic [W-1:0] c, input int t_fall, input int n_low,
                             input int n_edges, input logic [W-1:0] rx, input int t_done,
                             input int n_done, input int t_idle);
        chk({tag, ".sync_fall"}, 32'(t_fall),  32'(T + 1));
        chk({tag, ".sync_len"},  32'(n_low),   32'(W * 2 * cd));
        chk({tag, ".falls"},     32'(n_edges), 32'(W));
        chk({tag, ".data"},      32'(rx),      32'(bitrev(c)));
        chk({tag, ".done_t"},    32'(t_done),  32'(T + 1 + W * 2 * cd));
        chk({tag, ".done_n"},    32'(n_done),  32'(1));
        chk({tag, ".idle_t"},    32'(t_idle),  32'(T + 1 + W * 2 * cd + gap * cd));
    endtask

    initial begin
        int T, T2, tf, nl, ne, td, nd, ti, tf2, nl2, ne2, td2, nd2, ti2, cnt, falls, t_ab;
        logic [W-1:0] c1, c2, rx, rx2;
        logic prev;

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.sync_n", 32'(sync_n_a), 32'(1));
        chk("rst.sclk",   32'(sclk_a),   32'(1));
        chk("rst.din",    32'(din_a),    32'(0));
        chk("rst.busy",   32'(busy_a),   32'(0));
        chk("rst.done",   32'(done_a),   32'(0));
        chk("rst.b_sync", 32'(sync_n_b), 32'(1));
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame with the reference command
        c1 = bitrev(24'h3A5C30);
        cmd_a = c1; start_a = 1'b1; T = cyc;
        mon(1'b0, 1'b0, 400, -1, tf, nl, ne, rx, td, nd, ti);
        chk_frame("basic", T, CD_A, GAP_A, c1, tf, nl, ne, rx, td, nd, ti);
        chk("basic.word", 32'(rx), 32'h003A5C30);

        // Random single frames
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            c1 = W'($urandom);
            cmd_a = c1; start_a = 1'b1; T = cyc;
            mon(1'b0, 1'b0, 400, -1, tf, nl, ne, rx, td, nd, ti);
            chk_frame("rand", T, CD_A, GAP_A, c1, tf, nl, ne, rx, td, nd, ti);
        end

        // Back-to-back with start held high
        @(negedge clk);
        c1 = W'($urandom);
        cmd_a = c1; start_a = 1'b1; T = cyc;
        mon(1'b0, 1'b1, 400, -1, tf, nl, ne, rx, td, nd, ti);
        chk_frame("b2b1", T, CD_A, GAP_A, c1, tf, nl, ne, rx, td, nd, ti);
        c2 = W'($urandom);
        cmd_a = c2; T2 = cyc;
        mon(1'b0, 1'b0, 400, -1, tf2, nl2, ne2, rx2, td2, nd2, ti2);
        chk_frame("b2b2", T2, CD_A, GAP_A, c2, tf2, nl2, ne2, rx2, td2, nd2, ti2);
        chk("b2b.spacing", 32'(tf2), 32'(td + GAP_A * CD_A + 1));

        // Start pulse and cmd change mid-frame are ignored
        repeat (3) @(negedge clk);
        c1 = W'($urandom);
        cmd_a = c1; start_a = 1'b1; T = cyc;
        mon(1'b0, 1'b0, 400, 30, tf, nl, ne, rx, td, nd, ti);
        chk_frame("ign", T, CD_A, GAP_A, c1, tf, nl, ne, rx, td, nd, ti);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!sync_n_a || busy_a) cnt++;
        end
        chk("ign.no_second", 32'(cnt), 32'(0));

        // Reset after the 10th falling edge
        @(negedge clk);
        cmd_a = W'($urandom); start_a = 1'b1;
        falls = 0; prev = 1'b1;
        for (int i = 0; i < 200 && falls < 10; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (!sync_n_a && prev && !sclk_a) falls++;
            prev = sclk_a;
        end
        chk("rstmid.falls", 32'(falls), 32'(10));
        rst = 1'b0;
        #1;
        chk("rstmid.sync_n", 32'(sync_n_a), 32'(1));
        chk("rstmid.sclk",   32'(sclk_a),   32'(1));
        chk("rstmid.busy",   32'(busy_a),   32'(0));
        chk("rstmid.din",    32'(din_a),    32'(0));
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_a || !sync_n_a) cnt++;
        end
        chk("rstmid.quiet", 32'(cnt), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        c1 = W'($urandom);
        cmd_a = c1; start_a = 1'b1; T = cyc;
        mon(1'b0, 1'b0, 400, -1, tf, nl, ne, rx, td, nd, ti);
        chk_frame("post_rst", T, CD_A, GAP_A, c1, tf, nl, ne, rx, td, nd, ti);

        // Edge parameters: CLK_DIV=1, GAP_HP=0, all-ones then immediate restart
        @(negedge clk);
        c1 = '1;
        cmd_b = c1; start_b = 1'b1; T = cyc;
        mon(1'b1, 1'b1, 200, -1, tf, nl, ne, rx, td, nd, ti);
        chk_frame("edge1", T, CD_B, GAP_B, c1, tf, nl, ne, rx, td, nd, ti);
        c2 = W'($urandom);
        cmd_b = c2; T2 = cyc;
        mon(1'b1, 1'b0, 200, -1, tf2, nl2, ne2, rx2, td2, nd2, ti2);
        chk_frame("edge2", T2, CD_B, GAP_B, c2, tf2, nl2, ne2, rx2, td2, nd2, ti2);
        chk("edge.restart", 32'(tf2), 32'(td + 1));

`ifdef DAC_FRAME_ABORT_EN
        // Abort after the 5th falling edge
        repeat (2) @(negedge clk);
        cmd_a = W'($urandom); start_a = 1'b1;
        falls = 0; prev = 1'b1; t_ab = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (!sync_n_a && prev && !sclk_a) falls++;
            prev = sclk_a;
            if (falls == 5) begin
                abort_a = 1'b1;
                t_ab = cyc;
                break;
            end
        end
        @(negedge clk);
        abort_a = 1'b0;
        chk("abort.sync_n", 32'(sync_n_a), 32'(1));
        chk("abort.sclk",   32'(sclk_a),   32'(1));
        chk("abort.din",    32'(din_a),    32'(0));
        chk("abort.busy",   32'(busy_a),   32'(1));
        cnt = 0; ti = -1;
        for (int i = 0; i < 100; i++) begin
            if (done_a || !sync_n_a) cnt++;
            if (!busy_a) begin
                ti = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("abort.falls",  32'(falls), 32'(5));
        chk("abort.quiet",  32'(cnt),   32'(0));
        chk("abort.idle_t", 32'(ti),    32'(t_ab + 1 + GAP_A * CD_A));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
